// File: rtl/adc_frame_sched_if.sv
// adc_frame_sched_if: requester handshake, result bus and ADC serial pins
// shared between the frame scheduler (slave) and its environment (master).
interface adc_frame_sched_if;
    logic [1:0]  req;
    logic [1:0]  ack;
    logic        busy;
    logic        adc_sdata;
    logic        adc_sclk;
    logic        adc_cs_n;
    logic [11:0] data;
    logic        data_id;
    logic        data_valid;

    modport slave (
        input  req, adc_sdata,
        output ack, busy, adc_sclk, adc_cs_n, data, data_id, data_valid
    );

    modport master (
        output req, adc_sdata,
        input  ack, busy, adc_sclk, adc_cs_n, data, data_id, data_valid
    );
endinterface

// File: rtl/adc_frame_sched.sv
// adc_frame_sched: shares one serial 12-bit ADC between two requesters with
// round-robin arbitration. Each grant runs a 16-bit frame (4 leading zeros,
// 12 data bits MSB-first), followed by a quiet gap with chip select high.
// Optional build macro ADC_AVG_EN: every grant runs 4 frames and returns the
// truncated average of the 4 results.
//
// state  | meaning
// IDLE   | cs_n high, waiting for a request; grant issued on leaving
// SETUP  | cs_n low, sclk high for CLK_DIV cycles before the first fall
// SHIFT  | 16 sclk periods, sample at the end of each low phase
// QUIET  | cs_n high for QUIET_CYC cycles, busy still asserted
module adc_frame_sched #(
    parameter int CLK_DIV   = 8,
    parameter int QUIET_CYC = 16
) (
    input logic              clk,
    input logic              rst,
    adc_frame_sched_if.slave bus
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int QW    = (QUIET_CYC > 1) ? $clog2(QUIET_CYC) : 1;
    localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(CLK_DIV - 1);
    localparam logic [QW-1:0]    Q_LOAD   = QW'(QUIET_CYC - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT,
        ST_QUIET
    } state_t;

    state_t           state;
    logic [DIV_W-1:0] div_cnt;
    logic [4:0]       bit_cnt;
    logic [QW-1:0]    quiet_cnt;
    logic [11:0]      shreg;
    logic             rr_ptr;
    logic             winner;

    logic [1:0]       ack_r;
    logic             busy_r;
    logic             sclk_r;
    logic             cs_n_r;
    logic [11:0]      data_r;
    logic             data_id_r;
    logic             data_valid_r;

`ifdef ADC_AVG_EN
    logic [13:0]      acc;
    logic [13:0]      acc_sum;
    logic [1:0]       frame_cnt;

    // running sum including the frame that is just completing
    always_comb begin
        acc_sum = acc + {2'b00, shreg};
    end
`endif

    // round-robin winner: a lone requester wins, otherwise the one not served last
    always_comb begin
        winner = 1'b0;
        case (bus.req)
            2'b01:   winner = 1'b0;
            2'b10:   winner = 1'b1;
            default: winner = ~rr_ptr;
        endcase
    end

    // frame sequencer: arbitration, sclk/cs_n generation, shifting and result update
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            div_cnt      <= '0;
            bit_cnt      <= '0;
            quiet_cnt    <= '0;
            shreg        <= '0;
            rr_ptr       <= 1'b1;
            ack_r        <= 2'b00;
            busy_r       <= 1'b0;
            sclk_r       <= 1'b1;
            cs_n_r       <= 1'b1;
            data_r       <= 12'h800;
            data_id_r    <= 1'b0;
            data_valid_r <= 1'b0;
`ifdef ADC_AVG_EN
            acc          <= '0;
            frame_cnt    <= '0;
`endif
        end else begin
            ack_r        <= 2'b00;
            data_valid_r <= 1'b0;
            case (state)
                ST_IDLE: begin
                    sclk_r <= 1'b1;
                    cs_n_r <= 1'b1;
                    if (|bus.req) begin
                        ack_r   <= winner ? 2'b10 : 2'b01;
                        rr_ptr  <= winner;
                        busy_r  <= 1'b1;
                        cs_n_r  <= 1'b0;
                        div_cnt <= DIV_LOAD;
                        state   <= ST_SETUP;
`ifdef ADC_AVG_EN
                        acc       <= '0;
                        frame_cnt <= '0;
`endif
                    end
                end
                ST_SETUP: begin
                    if (div_cnt == '0) begin
                        sclk_r  <= 1'b0;
                        div_cnt <= DIV_LOAD;
                        bit_cnt <= '0;
                        state   <= ST_SHIFT;
                    end else begin
                        div_cnt <= div_cnt - 1'b1;
                    end
                end
                ST_SHIFT: begin
                    if (div_cnt != '0) begin
                        div_cnt <= div_cnt - 1'b1;
                    end else begin
                        div_cnt <= DIV_LOAD;
                        if (!sclk_r) begin
                            // end of a low phase: take the bit, leading zeros are dropped
                            sclk_r <= 1'b1;
                            if (bit_cnt >= 5'd4) begin
                                shreg <= {shreg[10:0], bus.adc_sdata};
                            end
                        end else if (bit_cnt == 5'd15) begin
                            cs_n_r    <= 1'b1;
                            quiet_cnt <= Q_LOAD;
                            state     <= ST_QUIET;
`ifdef ADC_AVG_EN
                            if (frame_cnt == 2'd3) begin
                                data_r       <= acc_sum[13:2];
                                data_id_r    <= rr_ptr;
                                data_valid_r <= 1'b1;
                                acc          <= '0;
                                frame_cnt    <= '0;
                            end else begin
                                acc       <= acc_sum;
                                frame_cnt <= frame_cnt + 1'b1;
                            end
`else
                            data_r       <= shreg;
                            data_id_r    <= rr_ptr;
                            data_valid_r <= 1'b1;
`endif
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                            sclk_r  <= 1'b0;
                        end
                    end
                end
                ST_QUIET: begin
                    sclk_r <= 1'b1;
                    if (quiet_cnt != '0) begin
                        quiet_cnt <= quiet_cnt - 1'b1;
`ifdef ADC_AVG_EN
                    end else if (frame_cnt != 2'd0) begin
                        // more frames of the same grant: no new arbitration
                        cs_n_r  <= 1'b0;
                        div_cnt <= DIV_LOAD;
                        state   <= ST_SETUP;
`endif
                    end else begin
                        busy_r <= 1'b0;
                        state  <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.ack        = ack_r;
    assign bus.busy       = busy_r;
    assign bus.adc_sclk   = sclk_r;
    assign bus.adc_cs_n   = cs_n_r;
    assign bus.data       = data_r;
    assign bus.data_id    = data_id_r;
    assign bus.data_valid = data_valid_r;

endmodule

// File: tb/tb_adc_frame_sched.sv
// tb_adc_frame_sched: directed bench for adc_frame_sched with a behavioural
// serial ADC that shifts out adc_word MSB-first, one bit per sclk fall.
module tb_adc_frame_sched;

    localparam int CLK_DIV   = 8;
    localparam int QUIET_CYC = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    logic [15:0] adc_word = 16'h0000;
    int          fall_cnt = 0;
    int          last_falls = 0;
    int          win_cnt = 0;
    int          dv_cnt = 0;
    logic        prev_cs_n = 1'b1;
    logic        prev_sclk = 1'b1;

    adc_frame_sched_if bus();

    adc_frame_sched #(
        .CLK_DIV   (CLK_DIV),
        .QUIET_CYC (QUIET_CYC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // ADC model: runs just after each active edge, reacts to cs_n/sclk transitions
    always begin
        logic [3:0] bit_idx;
        @(posedge clk);
        #2;
        if (prev_cs_n && !bus.adc_cs_n) begin
            fall_cnt = 0;
            win_cnt++;
        end
        if (!prev_cs_n && bus.adc_cs_n) last_falls = fall_cnt;
        if (prev_sclk && !bus.adc_sclk && !bus.adc_cs_n) begin
            if (fall_cnt < 16) begin
                bit_idx = 4'(15 - fall_cnt);
                bus.adc_sdata = adc_word[bit_idx];
            end
            fall_cnt++;
        end
        if (bus.data_valid === 1'b1) dv_cnt++;
        prev_cs_n = bus.adc_cs_n;
        prev_sclk = bus.adc_sclk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ack(input string tag, input int limit, output int at);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.ack === 2'b00 && n < limit);
        at = cyc;
        check(tag, 32'(bus.ack !== 2'b00), 32'd1);
    endtask

    task automatic wait_dv(input string tag, input int limit, output int at);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.data_valid !== 1'b1 && n < limit);
        at = cyc;
        check(tag, 32'(bus.data_valid), 32'd1);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (bus.busy !== 1'b0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(bus.busy), 32'd0);
    endtask

    task automatic wait_cs(input string tag, input logic level, input int limit);
        int n = 0;
        while (bus.adc_cs_n !== level && n < limit) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(bus.adc_cs_n), 32'(level));
    endtask

    initial begin
        int a, d, a2, d_prev, n, dv0, win0;
        logic [15:0] words [4];
        words[0] = 16'h0123;
        words[1] = 16'h0456;
        words[2] = 16'h0789;
        words[3] = 16'h0ABC;

        // reset held for 3 cycles
        bus.req = 2'b00;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_cs_n", 32'(bus.adc_cs_n), 32'd1);
        check("rst_sclk", 32'(bus.adc_sclk), 32'd1);
        check("rst_data", 32'(bus.data), 32'h800);
        check("rst_ack", 32'(bus.ack), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_dv", 32'(bus.data_valid), 32'd0);
        rst = 1'b0;

        // single request from requester 0
        adc_word = 16'h0ABC;
        bus.req = 2'b01;
        wait_ack("t2_ack_seen", 20, a);
        check("t2_ack", 32'(bus.ack), 32'h1);
        check("t2_busy", 32'(bus.busy), 32'd1);
        check("t2_cs_low", 32'(bus.adc_cs_n), 32'd0);
        bus.req = 2'b00;
        wait_dv("t2_dv_seen", 400, d);
        // request sampled on the edge before the ack cycle; result 265 cycles later
        check("t2_latency", 32'(d - (a - 1)), 32'd265);
        check("t2_data", 32'(bus.data), 32'hABC);
        check("t2_id", 32'(bus.data_id), 32'd0);
        check("t2_cs_high", 32'(bus.adc_cs_n), 32'd1);
        check("t2_falls", 32'(last_falls), 32'd16);
        @(negedge clk);
        check("t2_dv_pulse", 32'(bus.data_valid), 32'd0);
        n = 1;
        while (bus.busy === 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("t2_busy_len", 32'(n), 32'(QUIET_CYC));

        // both requesting from reset: alternate 0,1,0,1
        rst = 1'b1;
        bus.req = 2'b11;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        d_prev = 0;
        for (int i = 0; i < 4; i++) begin
            wait_ack($sformatf("t3_ack_seen%0d", i), 40, a);
            check($sformatf("t3_ack%0d", i), 32'(bus.ack), (i % 2 == 0) ? 32'h1 : 32'h2);
            adc_word = words[i];
            if (i > 0) check($sformatf("t3_gap%0d", i), 32'(a - d_prev >= QUIET_CYC + 1), 32'd1);
            if (i == 3) bus.req = 2'b00;
            wait_dv($sformatf("t3_dv_seen%0d", i), 400, d);
            check($sformatf("t3_id%0d", i), 32'(bus.data_id), 32'(i % 2));
            check($sformatf("t3_data%0d", i), 32'(bus.data), 32'(words[i][11:0]));
            d_prev = d;
        end
        wait_idle("t3_idle");

        // requester 1 alone, held: back-to-back frames
        adc_word = 16'h0F0F;
        bus.req = 2'b10;
        wait_ack("t4_ack1_seen", 40, a);
        check("t4_ack1", 32'(bus.ack), 32'h2);
        wait_dv("t4_dv1_seen", 400, d);
        check("t4_id1", 32'(bus.data_id), 32'd1);
        check("t4_data1", 32'(bus.data), 32'hF0F);
        check("t4_falls1", 32'(last_falls), 32'd16);
        adc_word = 16'h0321;
        wait_ack("t4_ack2_seen", 40, a2);
        bus.req = 2'b00;
        check("t4_ack2", 32'(bus.ack), 32'h2);
        check("t4_next_ack", 32'(a2 - d), 32'(QUIET_CYC + 1));
        wait_dv("t4_dv2_seen", 400, d);
        check("t4_data2", 32'(bus.data), 32'h321);
        check("t4_falls2", 32'(last_falls), 32'd16);
        wait_idle("t4_idle");

        // reset in the middle of SHIFT
        adc_word = 16'h0FFF;
        dv0 = dv_cnt;
        bus.req = 2'b01;
        wait_ack("t5_ack_seen", 40, a);
        bus.req = 2'b00;
        repeat (CLK_DIV + 100) @(negedge clk);
        check("t5_pre_cs", 32'(bus.adc_cs_n), 32'd0);
        check("t5_pre_sclk", 32'(bus.adc_sclk), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check("t5_cs_n", 32'(bus.adc_cs_n), 32'd1);
        check("t5_sclk", 32'(bus.adc_sclk), 32'd1);
        check("t5_data", 32'(bus.data), 32'h800);
        check("t5_busy", 32'(bus.busy), 32'd0);
        rst = 1'b0;
        repeat (300) @(negedge clk);
        check("t5_no_dv", 32'(dv_cnt - dv0), 32'd0);
        adc_word = 16'h0555;
        bus.req = 2'b01;
        wait_ack("t5_ack2_seen", 40, a);
        bus.req = 2'b00;
        wait_dv("t5_dv_seen", 400, d);
        check("t5_data2", 32'(bus.data), 32'h555);
        check("t5_id2", 32'(bus.data_id), 32'd0);
        wait_idle("t5_idle");

`ifdef ADC_AVG_EN
        // averaging: four frames per grant, one result
        adc_word = 16'h0100;
        dv0  = dv_cnt;
        win0 = win_cnt;
        bus.req = 2'b01;
        wait_ack("t6_ack_seen", 40, a);
        bus.req = 2'b00;
        for (int f = 1; f < 4; f++) begin
            wait_cs($sformatf("t6_cs_up%0d", f), 1'b1, 400);
            adc_word = 16'h0100 + 16'(f);
            wait_cs($sformatf("t6_cs_dn%0d", f), 1'b0, 40);
        end
        wait_dv("t6_dv_seen", 400, d);
        check("t6_data", 32'(bus.data), 32'h101);
        check("t6_windows", 32'(win_cnt - win0), 32'd4);
        check("t6_dv_count", 32'(dv_cnt - dv0), 32'd1);
        wait_idle("t6_idle");
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
